// File: rtl/local_buffer_dp.sv
// Dual-port word memory with per-lane write enables, write-through reads,
// and a self-running zero-fill sequencer that owns the array while busy.
module local_buffer_dp #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 16,
  parameter int DEPTH  = 64,
  localparam int LANES  = DATA_W / LANE_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CK,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              dbg_state,
  input  logic              a_en,
  input  logic [LANES-1:0]  a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic [LANES-1:0]  b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_a_acc, w_a_wr, w_a_rd, w_a_ok;
  logic w_b_acc, w_b_wr, w_b_rd, w_b_ok;
  logic [DATA_W-1:0] w_a_rdata, w_b_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (clr) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign busy      = (r_state == S_CLEAR);
  assign dbg_state = r_state;

  // Requests are only honoured in IDLE and outside reset.
  assign w_a_acc = a_en & ~busy & ~rst;
  assign w_b_acc = b_en & ~busy & ~rst;
  assign w_a_wr  = w_a_acc & (|a_we);
  assign w_b_wr  = w_b_acc & (|b_we);
  assign w_a_rd  = w_a_acc & ~(|a_we);
  assign w_b_rd  = w_b_acc & ~(|b_we);
  assign w_a_ok  = ({1'b0, a_addr} < DEPTH_EXT);
  assign w_b_ok  = ({1'b0, b_addr} < DEPTH_EXT);

  // Port B is applied first so port A wins on lanes both ports write.
  always_ff @(posedge CK) begin
    if (busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_b_wr && w_b_ok) begin
        for (int i = 0; i < LANES; i++) begin
          if (b_we[i]) r_mem[b_addr][i*LANE_W +: LANE_W] <= b_wdata[i*LANE_W +: LANE_W];
        end
      end
      if (w_a_wr && w_a_ok) begin
        for (int i = 0; i < LANES; i++) begin
          if (a_we[i]) r_mem[a_addr][i*LANE_W +: LANE_W] <= a_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // A read sees lanes the other port writes in the same cycle.
  always_comb begin
    w_a_rdata = w_a_ok ? r_mem[a_addr] : '0;
    w_b_rdata = w_b_ok ? r_mem[b_addr] : '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_b_wr && w_b_ok && (b_addr == a_addr) && b_we[i])
        w_a_rdata[i*LANE_W +: LANE_W] = b_wdata[i*LANE_W +: LANE_W];
      if (w_a_wr && w_a_ok && (a_addr == b_addr) && a_we[i])
        w_b_rdata[i*LANE_W +: LANE_W] = a_wdata[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= w_a_rd;
      b_rvalid <= w_b_rd;
      if (w_a_rd) a_rdata <= w_a_rdata;
      if (w_b_rd) b_rdata <= w_b_rdata;
    end
  end

endmodule

// File: tb/tb_local_buffer_dp.sv
// Directed bench for local_buffer_dp: vector table for single-cycle port
// behaviour plus sequences for clear, reset-during-clear and out-of-range.
module tb_local_buffer_dp;
  localparam int DW = 128;
  localparam int LN = 8;
  localparam int AW = 6;

  localparam logic [DW-1:0] P_A   = {8{16'hAAAA}};
  localparam logic [DW-1:0] P_1   = {8{16'hFFFF}};
  localparam logic [DW-1:0] P_LO  = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] P_12  = {8{16'h1234}};
  localparam logic [DW-1:0] P_A12 = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_1234;
  localparam logic [DW-1:0] P_55  = {8{16'h5555}};
  localparam logic [DW-1:0] P_33  = {8{16'h3333}};
  localparam logic [DW-1:0] P_53  = 128'h5555_0000_0000_0000_0000_0000_0000_3333;

  // clock / reset
  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst, clr, busy, dbg_state;
  logic a_en, b_en, a_rvalid, b_rvalid;
  logic [LN-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;

  logic d2_rst, d2_clr, d2_busy, d2_dbg_state;
  logic d2_a_en, d2_b_en, d2_a_rvalid, d2_b_rvalid;
  logic [LN-1:0] d2_a_we, d2_b_we;
  logic [AW-1:0] d2_a_addr, d2_b_addr;
  logic [DW-1:0] d2_a_wdata, d2_b_wdata, d2_a_rdata, d2_b_rdata;

  local_buffer_dp dut (
    .CK(CK), .rst(rst), .clr(clr), .busy(busy), .dbg_state(dbg_state),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  local_buffer_dp #(.DEPTH(48)) dut48 (
    .CK(CK), .rst(d2_rst), .clr(d2_clr), .busy(d2_busy), .dbg_state(d2_dbg_state),
    .a_en(d2_a_en), .a_we(d2_a_we), .a_addr(d2_a_addr), .a_wdata(d2_a_wdata),
    .a_rdata(d2_a_rdata), .a_rvalid(d2_a_rvalid),
    .b_en(d2_b_en), .b_we(d2_b_we), .b_addr(d2_b_addr), .b_wdata(d2_b_wdata),
    .b_rdata(d2_b_rdata), .b_rvalid(d2_b_rvalid)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          a_en;
    logic [LN-1:0] a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_en;
    logic [LN-1:0] b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          exp_a_rv;
    logic [DW-1:0] exp_a_rd;
    logic          exp_b_rv;
    logic [DW-1:0] exp_b_rd;
  } vec_t;

  vec_t vecs[11];

  // driver tasks
  task automatic cycle();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_ports();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic idle_ports2();
    d2_a_en = 1'b0; d2_a_we = '0; d2_a_addr = '0; d2_a_wdata = '0;
    d2_b_en = 1'b0; d2_b_we = '0; d2_b_addr = '0; d2_b_wdata = '0;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i) + 16'h0100;
    return {8{v}};
  endfunction

  // Counts cycles with busy high, starting from the current (busy) cycle.
  task automatic count_busy1(output int n, output logic saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (busy && n < 200) begin
      n++;
      cycle();
      saw_rv = saw_rv | a_rvalid | b_rvalid;
    end
  endtask

  task automatic count_busy2(output int n);
    n = 0;
    while (d2_busy && n < 200) begin
      n++;
      cycle();
    end
  endtask

  task automatic read_all_zero1(input string tag);
    for (int i = 0; i < 64; i++) begin
      a_en = 1'b1; a_we = '0; a_addr = AW'(i);
      b_en = 1'b1; b_we = '0; b_addr = AW'(63 - i);
      exp_q.push_back('0);
      cycle();
      check({tag, "_a_rvalid"}, DW'(a_rvalid), DW'(1));
      if (a_rvalid) check({tag, "_a_rdata"}, a_rdata, exp_q.pop_front());
      check({tag, "_b_rvalid"}, DW'(b_rvalid), DW'(1));
      check({tag, "_b_rdata"}, b_rdata, '0);
    end
    idle_ports();
    check({tag, "_queue_left"}, DW'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic sv;

    vecs[0]  = '{1'b1, 8'hFF, 6'd5, P_A,  1'b1, 8'h00, 6'd5,  '0,   1'b0, '0,    1'b1, P_A};
    vecs[1]  = '{1'b1, 8'h0F, 6'd9, P_1,  1'b1, 8'hFF, 6'd9,  '0,   1'b0, '0,    1'b0, P_A};
    vecs[2]  = '{1'b1, 8'h00, 6'd9, '0,   1'b1, 8'h00, 6'd9,  '0,   1'b1, P_LO,  1'b1, P_LO};
    vecs[3]  = '{1'b0, 8'h00, 6'd0, '0,   1'b0, 8'h00, 6'd0,  '0,   1'b0, P_LO,  1'b0, P_LO};
    vecs[4]  = '{1'b1, 8'h00, 6'd5, '0,   1'b1, 8'h01, 6'd5,  P_12, 1'b1, P_A12, 1'b0, P_LO};
    vecs[5]  = '{1'b1, 8'h80, 6'd7, P_55, 1'b1, 8'h81, 6'd7,  P_33, 1'b0, P_A12, 1'b0, P_LO};
    vecs[6]  = '{1'b1, 8'h00, 6'd7, '0,   1'b1, 8'h00, 6'd7,  '0,   1'b1, P_53,  1'b1, P_53};
    vecs[7]  = '{1'b1, 8'h00, 6'd5, '0,   1'b0, 8'h00, 6'd0,  '0,   1'b1, P_A12, 1'b0, P_53};
    vecs[8]  = '{1'b0, 8'hFF, 6'd5, '0,   1'b1, 8'h00, 6'd5,  '0,   1'b0, P_A12, 1'b1, P_A12};
    vecs[9]  = '{1'b1, 8'h00, 6'd63, '0,  1'b1, 8'hFF, 6'd63, P_1,  1'b1, P_1,   1'b0, P_A12};
    vecs[10] = '{1'b1, 8'h00, 6'd0, '0,   1'b1, 8'h00, 6'd63, '0,   1'b1, '0,    1'b1, P_1};

    idle_ports();
    idle_ports2();
    clr = 1'b0; d2_clr = 1'b0;
    rst = 1'b1; d2_rst = 1'b1;
    repeat (3) cycle();

    check("rst_busy", DW'(busy), DW'(1));
    check("rst_a_rvalid", DW'(a_rvalid), '0);
    check("rst_b_rvalid", DW'(b_rvalid), '0);
    check("rst_a_rdata", a_rdata, '0);
    check("rst_b_rdata", b_rdata, '0);

    rst = 1'b0;
    count_busy1(n, sv);
    check("init_busy_cycles", DW'(n), DW'(64));
    read_all_zero1("init_read");

    for (int i = 0; i < 11; i++) begin
      a_en = vecs[i].a_en; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_en = vecs[i].b_en; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      cycle();
      check($sformatf("vec%0d_a_rvalid", i), DW'(a_rvalid), DW'(vecs[i].exp_a_rv));
      check($sformatf("vec%0d_a_rdata", i), a_rdata, vecs[i].exp_a_rd);
      check($sformatf("vec%0d_b_rvalid", i), DW'(b_rvalid), DW'(vecs[i].exp_b_rv));
      check($sformatf("vec%0d_b_rdata", i), b_rdata, vecs[i].exp_b_rd);
    end
    idle_ports();

    // DEPTH=48 instance: out-of-range address handling.
    d2_rst = 1'b0;
    count_busy2(n);
    check("d48_busy_cycles", DW'(n), DW'(48));
    d2_a_en = 1'b1; d2_a_we = 8'hFF; d2_a_addr = 6'd50; d2_a_wdata = P_1;
    d2_b_en = 1'b1; d2_b_we = 8'hFF; d2_b_addr = 6'd10; d2_b_wdata = P_1;
    cycle();
    check("d48_wr_no_rvalid", DW'(d2_a_rvalid | d2_b_rvalid), '0);
    idle_ports2();
    d2_a_en = 1'b1; d2_a_addr = 6'd10;
    cycle();
    check("d48_rd10_rvalid", DW'(d2_a_rvalid), DW'(1));
    check("d48_rd10_rdata", d2_a_rdata, P_1);
    d2_a_addr = 6'd50;
    d2_b_en = 1'b1; d2_b_addr = 6'd2;
    cycle();
    check("d48_rd50_rvalid", DW'(d2_a_rvalid), DW'(1));
    check("d48_rd50_rdata", d2_a_rdata, '0);
    check("d48_rd2_rvalid", DW'(d2_b_rvalid), DW'(1));
    check("d48_rd2_rdata", d2_b_rdata, '0);
    idle_ports2();

    // Fill, clear, reset mid-clear, requests while busy.
    for (int i = 0; i < 64; i++) begin
      a_en = 1'b1; a_we = 8'hFF; a_addr = AW'(i); a_wdata = pat(i);
      cycle();
    end
    idle_ports();
    a_en = 1'b1; a_addr = 6'd3;
    b_en = 1'b1; b_addr = 6'd60;
    cycle();
    check("fill_rd3", a_rdata, pat(3));
    check("fill_rd60", b_rdata, pat(60));
    idle_ports();

    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_busy", DW'(busy), DW'(1));
    a_en = 1'b1; a_we = '0; a_addr = 6'd3;
    b_en = 1'b1; b_we = 8'hFF; b_addr = 6'd30; b_wdata = P_1;
    sv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      sv = sv | a_rvalid | b_rvalid;
    end
    check("busy_no_rvalid_pre", DW'(sv), '0);
    check("busy_rdata_hold", a_rdata, pat(3));
    check("busy_mid_clear", DW'(busy), DW'(1));

    rst = 1'b1;
    cycle();
    check("midrst_busy", DW'(busy), DW'(1));
    check("midrst_rvalid", DW'(a_rvalid | b_rvalid), '0);
    check("midrst_a_rdata", a_rdata, '0);
    check("midrst_b_rdata", b_rdata, '0);
    rst = 1'b0;
    clr = 1'b1;
    count_busy1(n, sv);
    clr = 1'b0;
    idle_ports();
    check("restart_busy_cycles", DW'(n), DW'(64));
    check("busy_no_rvalid_post", DW'(sv), '0);
    read_all_zero1("after_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/local_buffer_dp.md
LOCAL_BUFFER_DP -- requirements
Module: local_buffer_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 128: word width in bits.
REQ-002 SHALL have parameter LANE_W, default 16: write-lane width; DATA_W SHALL be an integer multiple of LANE_W; LANES = DATA_W/LANE_W.
REQ-003 SHALL have parameter DEPTH, default 64: words stored, 2..4096, need not be a power of two; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have port CK  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port clr  input  1  request a full-memory zero fill, sampled in IDLE only.
REQ-007 SHALL have port busy  output  1  high while clear is in progress.
REQ-008 SHALL have ports a_en, b_en  input  1  access request on port A / B.
REQ-009 SHALL have ports a_we, b_we  input  LANES  active-high lane write enables; all zero with en=1 means read.
REQ-010 SHALL have ports a_addr, b_addr  input  ADDR_W  word address.
REQ-011 SHALL have ports a_wdata, b_wdata  input  DATA_W  write data.
REQ-012 SHALL have ports a_rdata, b_rdata  output  DATA_W  registered read data.
REQ-013 SHALL have ports a_rvalid, b_rvalid  output  1  one-cycle pulse, rdata valid.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and IDLE; rst forces CLEAR with clear counter 0.
REQ-015 In CLEAR, SHALL write all-zero to address = counter each cycle, increment counter, go to IDLE in the cycle after writing DEPTH-1; busy=1 throughout CLEAR.
REQ-016 In IDLE, clr=1 SHALL enter CLEAR with counter 0 on the next cycle; clr is ignored in CLEAR.
REQ-017 While busy=1, port requests SHALL be ignored: no writes, rvalid=0, rdata holds.
REQ-018 Read (en=1, we=0) accepted in cycle N SHALL produce rvalid=1 and rdata in cycle N+1; latency exactly 1, no stalls, one access per port per cycle.
REQ-019 rdata SHALL hold its last value until the next accepted read on that port.
REQ-020 Write (en=1, we!=0) SHALL update only lanes with we[i]=1 at end of cycle; no rvalid pulse.
REQ-021 Both ports writing the same address in one cycle: lanes written by both SHALL take port A data; lanes written by one port SHALL take that port's data.
REQ-022 One port reading an address the other port writes in the same cycle SHALL return the new data in written lanes and old data in other lanes (write-through).
REQ-023 Both ports reading the same address SHALL both return identical data, both rvalid=1.
REQ-024 Address >= DEPTH: writes SHALL be discarded; reads SHALL return all-zero with rvalid=1.
REQ-025 Port A and port B SHALL be fully independent apart from REQ-021..REQ-023; no address remapping.

Reset
REQ-026 Under rst: busy=1 next cycle, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, FSM=CLEAR, counter=0.
REQ-027 rst asserted mid-clear or mid-access SHALL restart the clear from address 0; in-flight reads produce no rvalid.
REQ-028 After a completed clear every word SHALL read 0.

Verification
REQ-029 Reset, DEPTH=64: busy high exactly 64 cycles after rst release; then read all addresses -> all 0, each rvalid one cycle after request.
REQ-030 A writes addr 5 = 0x...AAAA all lanes; B reads addr 5 same cycle -> b_rdata=0x...AAAA next cycle (write-through).
REQ-031 A writes addr 9 we=0x0F data all 1s; B writes addr 9 we=0xFF data all 0s same cycle -> readback lanes 0-3 = 0xFFFF, lanes 4-7 = 0x0000.
REQ-032 DEPTH=48: write addr 50 then read addr 50 -> rdata=0, rvalid=1, addr 50 mod 48 unchanged.
REQ-033 Fill memory, assert clr, assert rst at counter=20 -> clear restarts at 0, busy DEPTH cycles, all words 0 after.
REQ-034 Requests issued while busy=1 -> no rvalid, memory content after clear all 0.
